// File: rtl/spi_slave_param.sv
// SPI slave front-end: collects {cmd, payload} frames from MOSI and, for read-data
// commands, waits for a reply word and shifts it out on MISO.
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              SCK,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              frame_err,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int TO_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;
    localparam logic [2:0] WAIT_TX   = 3'd5;
    localparam logic [2:0] SEND      = 3'd6;

    logic [2:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TO_W-1:0]   wait_cnt;
    logic              rd_addr_seen;
    logic              cmd_hi;
    logic              cmd_lo;
    logic [DATA_W-1:0] pay_sr;
    logic [DATA_W-1:0] tx_sr;

    logic [DATA_W-1:0] pay_next;
    logic [DATA_W-1:0] tx_load;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_first;
    logic              tx_bit;
    logic              shifting;
    logic              completing;

    // Bit-order dependent views of the receive and transmit shift registers.
    always_comb begin
        if (MSB_FIRST) begin
            pay_next = {pay_sr[DATA_W-2:0], MOSI};
            tx_first = tx_data[DATA_W-1];
            tx_load  = {tx_data[DATA_W-2:0], 1'b0};
            tx_bit   = tx_sr[DATA_W-1];
            tx_shift = {tx_sr[DATA_W-2:0], 1'b0};
        end else begin
            pay_next = {MOSI, pay_sr[DATA_W-1:1]};
            tx_first = tx_data[0];
            tx_load  = {1'b0, tx_data[DATA_W-1:1]};
            tx_bit   = tx_sr[0];
            tx_shift = {1'b0, tx_sr[DATA_W-1:1]};
        end
    end

    assign shifting   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    // A frame finishing on this edge takes priority over a concurrent SS_n release.
    assign completing = (shifting && (bit_cnt == CNT_W'(DATA_W))) ||
                        ((state == SEND) && (bit_cnt == CNT_W'(DATA_W - 1)));
    assign busy       = (state != IDLE);

    always_ff @(posedge SCK or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            rd_addr_seen <= 1'b0;
            cmd_hi       <= 1'b0;
            cmd_lo       <= 1'b0;
            pay_sr       <= '0;
            tx_sr        <= '0;
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (SS_n && (state != IDLE) && !completing) begin
                state     <= IDLE;
                MISO      <= 1'b0;
                bit_cnt   <= '0;
                wait_cnt  <= '0;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        if (!SS_n) state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        cmd_hi  <= MOSI;
                        bit_cnt <= '0;
                        if (!MOSI)             state <= WRITE;
                        else if (rd_addr_seen) state <= READ_DATA;
                        else                   state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (completing) begin
                            rx_data  <= {cmd_hi, cmd_lo, pay_next};
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            wait_cnt <= '0;
                            if (state == READ_DATA) begin
                                state        <= WAIT_TX;
                                rd_addr_seen <= 1'b0;
                            end else begin
                                state <= IDLE;
                                if (state == READ_ADD) rd_addr_seen <= 1'b1;
                            end
                        end else begin
                            if (bit_cnt == '0) cmd_lo <= MOSI;
                            else               pay_sr <= pay_next;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    WAIT_TX: begin
                        MISO <= 1'b0;
                        if (tx_valid) begin
                            MISO    <= tx_first;
                            tx_sr   <= tx_load;
                            bit_cnt <= '0;
                            state   <= SEND;
                        end else if ((TX_TIMEOUT > 0) && (wait_cnt == TO_W'(TX_TIMEOUT - 1))) begin
                            frame_err <= 1'b1;
                            wait_cnt  <= '0;
                            state     <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    SEND: begin
                        if (completing) begin
                            MISO    <= 1'b0;
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            MISO    <= tx_bit;
                            tx_sr   <= tx_shift;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        MISO  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised scoreboard bench for spi_slave_param: a transaction-level model predicts
// per-cycle outputs and frame events; a monitor pops and compares them each cycle.
module tb_spi_slave_param;
    localparam int DW  = 8;
    localparam bit MSB = 1'b1;
    localparam int TO  = 16;
    localparam int FW  = DW + 2;

    logic          SCK = 1'b0;
    logic          rst;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [FW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          frame_err;
    logic          busy;

    logic          ss_b;
    logic          mosi_b;
    logic          miso_b;
    logic [17:0]   rx_data_b;
    logic          rx_valid_b;
    logic [15:0]   tx_data_b;
    logic          tx_valid_b;
    logic          frame_err_b;
    logic          busy_b;

    always #5 SCK = ~SCK;

    spi_slave_param #(.DATA_W(DW), .MSB_FIRST(MSB), .TX_TIMEOUT(TO)) dut (
        .SCK(SCK), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .frame_err(frame_err), .busy(busy)
    );

    spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0), .TX_TIMEOUT(0)) dut_b (
        .SCK(SCK), .rst(rst), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .frame_err(frame_err_b), .busy(busy_b)
    );

    typedef struct packed {
        logic          miso;
        logic          busy;
        logic          rxv;
        logic          ferr;
        logic [FW-1:0] rxd;
    } cyc_t;

    typedef struct packed {
        logic          is_err;
        logic [FW-1:0] rxd;
    } evt_t;

    cyc_t          cyc_q[$];
    evt_t          evt_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [FW-1:0] model_rx;
    bit            model_rd_seen;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [DW-1:0] bit_reverse(input logic [DW-1:0] v);
        for (int k = 0; k < DW; k++) bit_reverse[k] = v[DW-1-k];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one SCK cycle and record what the outputs must look like after its posedge.
    task automatic applyStimulus(input logic ss, input logic mosi, input logic txv,
                                 input logic [DW-1:0] txd, input logic e_miso,
                                 input logic e_busy, input logic e_rxv, input logic e_ferr);
        cyc_t c;
        SS_n     = ss;
        MOSI     = mosi;
        tx_valid = txv;
        tx_data  = txd;
        c = '{e_miso, e_busy, e_rxv, e_ferr, model_rx};
        cyc_q.push_back(c);
        @(negedge SCK);
        #1;
    endtask

    task automatic apply_reset();
        cyc_t c;
        rst      = 1'b1;
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        #1;
        checkOutput("reset_immediate", 64'({MISO, busy, rx_valid, frame_err, rx_data}), 64'd0);
        model_rx      = '0;
        model_rd_seen = 1'b0;
        c = '0;
        cyc_q.push_back(c);
        @(negedge SCK);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_gap(input int n);
        for (int g = 0; g < n; g++) applyStimulus(1'b1, rb(), 1'b0, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One command frame; abort_at = edge index (1..FW) where SS_n is seen high, 0 for none.
    task automatic do_frame(input logic [1:0] cmd, input logic [DW-1:0] pay, input int abort_at,
                            output bit to_wait);
        logic [FW-1:0] bits;
        bit            rd;
        evt_t          ev;
        bits    = {cmd, (MSB ? pay : bit_reverse(pay))};
        to_wait = 1'b0;
        applyStimulus(1'b0, rb(), rb(), DW'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= FW; i++) begin
            if (i < FW && abort_at == i) begin
                ev = '{1'b1, model_rx};
                evt_q.push_back(ev);
                applyStimulus(1'b1, bits[FW-i], rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            if (i < FW) begin
                applyStimulus(1'b0, bits[FW-i], rb(), DW'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
            end else begin
                rd = cmd[1] && model_rd_seen;
                if (cmd[1]) model_rd_seen = !model_rd_seen;
                model_rx = {cmd, pay};
                ev = '{1'b0, model_rx};
                evt_q.push_back(ev);
                applyStimulus(abort_at == FW, bits[0], rb(), DW'($urandom), 1'b0, rd, 1'b1, 1'b0);
                to_wait = rd;
            end
        end
    endtask

    // Reply phase after a read-data frame; -1 disables each abort/reset option.
    task automatic do_reply(input int delay, input logic [DW-1:0] txd, input int wait_abort,
                            input int send_abort, input int send_reset);
        logic [DW-1:0] order;
        evt_t          ev;
        order = MSB ? txd : bit_reverse(txd);
        for (int w = 0; w < 64; w++) begin
            if (w == wait_abort) begin
                ev = '{1'b1, model_rx};
                evt_q.push_back(ev);
                applyStimulus(1'b1, rb(), rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            if (w == delay) begin
                applyStimulus(1'b0, rb(), 1'b1, txd, order[DW-1], 1'b1, 1'b0, 1'b0);
                break;
            end
            if (TO > 0 && w == TO - 1) begin
                ev = '{1'b1, model_rx};
                evt_q.push_back(ev);
                applyStimulus(1'b0, rb(), 1'b0, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            applyStimulus(1'b0, rb(), 1'b0, DW'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        for (int j = 1; j <= DW; j++) begin
            if (j == send_reset) begin
                apply_reset();
                return;
            end
            if (j < DW && j == send_abort) begin
                ev = '{1'b1, model_rx};
                evt_q.push_back(ev);
                applyStimulus(1'b1, rb(), rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            if (j < DW)
                applyStimulus(1'b0, rb(), rb(), DW'($urandom), order[DW-1-j], 1'b1, 1'b0, 1'b0);
            else
                applyStimulus(send_abort == DW, rb(), rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Monitor: per-cycle expectations plus frame events on rx_valid / frame_err.
    initial begin
        cyc_t e;
        evt_t v;
        forever begin
            @(negedge SCK);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                checkOutput("cycle{miso,busy,rx_valid,frame_err,rx_data}",
                            64'({MISO, busy, rx_valid, frame_err, rx_data}), 64'(e));
            end
            if (rx_valid || frame_err) begin
                if (evt_q.size() > 0) begin
                    v = evt_q.pop_front();
                    checkOutput("event{frame_err,rx_data}", 64'({frame_err, rx_data}), 64'(v));
                end else begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_event: got rx_valid=%b frame_err=%b, expected none at %0t",
                             rx_valid, frame_err, $time);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step_b(input logic ss, input logic mosi, input logic txv, input logic [15:0] txd);
        ss_b       = ss;
        mosi_b     = mosi;
        tx_valid_b = txv;
        tx_data_b  = txd;
        @(negedge SCK);
        #1;
    endtask

    task automatic frame_b(input logic [1:0] cmd, input logic [15:0] pay);
        step_b(1'b0, 1'b0, 1'b0, 16'h0);
        step_b(1'b0, cmd[1], 1'b0, 16'h0);
        step_b(1'b0, cmd[0], 1'b0, 16'h0);
        for (int k = 0; k < 15; k++) step_b(1'b0, pay[k], 1'b0, 16'h0);
        checkOutput("b_no_early_rx_valid", 64'(rx_valid_b), 64'd0);
        step_b(1'b0, pay[15], 1'b0, 16'h0);
    endtask

    bit            to_wait;
    logic [1:0]    cmd;
    logic [DW-1:0] pay;
    int            abort_at;
    int            r;
    int            delay;
    logic [15:0]   reply_b;
    bit            err_seen_b;

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        ss_b = 1'b1; mosi_b = 1'b0; tx_valid_b = 1'b0; tx_data_b = '0;
        model_rx = '0; model_rd_seen = 1'b0;
        #1;
        checkOutput("reset_state", 64'({MISO, busy, rx_valid, frame_err, rx_data}), 64'd0);
        @(negedge SCK);
        #1;
        rst = 1'b0;

        $display("[TB] directed: write, read-addr/read-data reply, timeout, aborts, reset");
        do_frame(2'b00, 8'hA5, 0, to_wait);
        do_gap(1);
        do_frame(2'b10, 8'h3C, 0, to_wait);
        do_frame(2'b11, DW'($urandom), 0, to_wait);
        do_reply(0, 8'hC3, -1, -1, -1);
        do_gap(1);
        do_frame(2'b10, 8'h11, 0, to_wait);
        do_frame(2'b11, 8'h22, 0, to_wait);
        do_reply(TO + 5, 8'hFF, -1, -1, -1);
        do_gap(1);
        do_frame(2'b00, 8'h5A, 6, to_wait);
        do_gap(1);
        do_frame(2'b10, 8'h33, 0, to_wait);
        do_frame(2'b11, 8'h44, 0, to_wait);
        do_reply(2, 8'h96, -1, -1, 4);
        do_gap(1);
        do_frame(2'b00, 8'h01, 0, to_wait);
        do_frame(2'b01, 8'h80, 0, to_wait);
        do_frame(2'b00, 8'h7E, FW, to_wait);
        do_frame(2'b10, 8'h55, 0, to_wait);
        do_frame(2'b11, 8'hAA, 0, to_wait);
        do_reply(TO - 1, 8'h5A, -1, DW, -1);
        do_gap(2);

        $display("[TB] randomized transactions");
        repeat (150) begin
            cmd      = 2'($urandom);
            pay      = DW'($urandom);
            r        = $urandom_range(0, 9);
            abort_at = 0;
            if (r == 0) abort_at = $urandom_range(1, FW - 1);
            else if (r == 1 && !cmd[1]) abort_at = FW;
            do_frame(cmd, pay, abort_at, to_wait);
            if (to_wait) begin
                r     = $urandom_range(0, 9);
                delay = (r == 0) ? TO + 2 : (r == 1) ? TO - 1 : $urandom_range(0, 5);
                do_reply(delay, DW'($urandom),
                         (r == 2) ? $urandom_range(0, delay) : -1,
                         (r == 3) ? $urandom_range(1, DW) : -1,
                         (r == 4) ? $urandom_range(1, DW) : -1);
            end
            if ($urandom_range(0, 2) == 0) do_gap($urandom_range(1, 3));
        end
        do_gap(2);
        checkOutput("cycle_queue_drained", 64'(cyc_q.size()), 64'd0);
        checkOutput("event_queue_drained", 64'(evt_q.size()), 64'd0);

        $display("[TB] 16-bit LSB-first instance, no tx timeout");
        frame_b(2'b00, 16'h0001);
        checkOutput("b_rx_valid", 64'(rx_valid_b), 64'd1);
        checkOutput("b_rx_data", 64'(rx_data_b), 64'h00001);
        frame_b(2'b10, 16'h0000);
        checkOutput("b_read_addr_idle", 64'(busy_b), 64'd0);
        frame_b(2'b11, 16'h0000);
        checkOutput("b_read_data_wait", 64'(busy_b), 64'd1);
        err_seen_b = 1'b0;
        repeat (40) begin
            step_b(1'b0, 1'b0, 1'b0, 16'h1234);
            err_seen_b |= frame_err_b;
        end
        checkOutput("b_wait_forever", 64'({busy_b, err_seen_b, miso_b}), 64'b100);
        reply_b = 16'h8000;
        step_b(1'b0, 1'b0, 1'b1, reply_b);
        checkOutput("b_miso_bit0", 64'(miso_b), 64'(reply_b[0]));
        for (int k = 1; k < 16; k++) begin
            step_b(1'b0, 1'b0, 1'b0, 16'h0);
            checkOutput("b_miso_bit", 64'(miso_b), 64'(reply_b[k]));
        end
        step_b(1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("b_send_done", 64'({miso_b, busy_b}), 64'd0);
        step_b(1'b1, 1'b0, 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
